// File: rtl/sram_dp_fill.sv
// Dual-port SRAM (one write, one read port) with a hardware fill engine that sweeps a constant value across the array.
// Optional macro SRAM_OUTREG_EN adds an output pipeline stage on o_rdata/o_rvalid (read latency 2).
module sram_dp_fill #(
  parameter int    ADDR_WIDTH = 8,
  parameter int    DATA_WIDTH = 8,
  parameter int    DEPTH      = 256,
  parameter string MEMFILE    = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  input  logic                  i_fill_start,
  input  logic [DATA_WIDTH-1:0] i_fill_data,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  fill_state_t           state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] fill_val;
  logic                  fill_we;
  logic                  user_we;
  logic                  raddr_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  assign fill_we  = (state == FILL);
  assign user_we  = i_write && !o_busy && ({1'b0, i_waddr} < DEPTH_EXT);
  assign raddr_ok = ({1'b0, i_raddr} < DEPTH_EXT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_val <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_fill_start) begin
            state    <= FILL;
            fill_val <= i_fill_data;
            cnt      <= '0;
            o_busy   <= 1'b1;
          end
        end
        FILL: begin
          // The last address is written on the same edge that leaves FILL.
          if (cnt == LAST_ADDR) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          cnt    <= '0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset so contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (fill_we) begin
      mem[cnt] <= fill_val;
    end else if (user_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= i_read;
      if (i_read) begin
        rd_data <= raddr_ok ? mem[i_raddr] : '0;
      end
    end
  end

`ifdef SRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data;
      rd_valid_q <= rd_valid;
    end
  end

  assign o_rdata  = rd_data_q;
  assign o_rvalid = rd_valid_q;
`else
  assign o_rdata  = rd_data;
  assign o_rvalid = rd_valid;
`endif

endmodule

// File: tb/tb_sram_dp_fill.sv
// Directed self-checking bench for sram_dp_fill (DEPTH=16, 4-bit address, 8-bit data).
// Read latency follows SRAM_OUTREG_EN so the same bench covers both builds.
module tb_sram_dp_fill;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DP = 16;
`ifdef SRAM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic          i_clk;
  logic          i_rst_n;
  logic [AW-1:0] i_waddr;
  logic          i_write;
  logic [DW-1:0] i_wdata;
  logic [AW-1:0] i_raddr;
  logic          i_read;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid;
  logic          i_fill_start;
  logic [DW-1:0] i_fill_data;
  logic          o_busy;
  logic          o_done;

  int n_cmp  = 0;
  int n_fail = 0;

  sram_dp_fill #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .MEMFILE   ("")
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_waddr     (i_waddr),
    .i_write     (i_write),
    .i_wdata     (i_wdata),
    .i_raddr     (i_raddr),
    .i_read      (i_read),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .i_fill_start(i_fill_start),
    .i_fill_data (i_fill_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_waddr = a;
    i_wdata = d;
    i_write = 1'b1;
    tick();
    i_write = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    i_raddr = a;
    i_read  = 1'b1;
    tick();
    i_read  = 1'b0;
    if (RD_LAT == 2) tick();
    d = o_rdata;
    v = o_rvalid;
  endtask

  task automatic start_fill(input logic [DW-1:0] val);
    i_fill_data  = val;
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
  endtask

  // Samples 40 cycles; gap is the cycle distance from the last busy sample to the first done pulse.
  task automatic count_fill(inout int busy_cnt, output int done_cnt, output int gap);
    int last_busy = 0;
    int done_at   = -100;
    done_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (o_busy) begin
        busy_cnt++;
        last_busy = i;
      end
      if (o_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    gap = done_at - last_busy;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_waddr = '0; i_write = 1'b0; i_wdata = '0;
    i_raddr = '0; i_read = 1'b0;
    i_fill_start = 1'b0; i_fill_data = '0;
    #12;
    n_cmp++; if (o_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", o_rdata); end
    n_cmp++; if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", o_rvalid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_done); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    logic v;
    do_write(4'd3, 8'hA5);
    do_read(4'd3, d, v);
    n_cmp++; if (d !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_data: got %h expected a5", d); end
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid: got %b expected 1", v); end
    tick();
    n_cmp++; if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b expected 0", o_rvalid); end
    n_cmp++; if (o_rdata !== 8'hA5) begin n_fail++; $display("FAIL idle_rdata_hold: got %h expected a5", o_rdata); end
  endtask

  task automatic test_read_first();
    logic [DW-1:0] d;
    logic v;
    do_write(4'd5, 8'h22);
    i_waddr = 4'd5; i_wdata = 8'h11; i_write = 1'b1;
    i_raddr = 4'd5; i_read = 1'b1;
    tick();
    i_write = 1'b0; i_read = 1'b0;
    if (RD_LAT == 2) tick();
    n_cmp++; if (o_rdata !== 8'h22) begin n_fail++; $display("FAIL read_first_old: got %h expected 22", o_rdata); end
    do_read(4'd5, d, v);
    n_cmp++; if (d !== 8'h11) begin n_fail++; $display("FAIL read_first_new: got %h expected 11", d); end
  endtask

  task automatic test_fill();
    int bc, dc, gap;
    logic [DW-1:0] d;
    logic v;
    start_fill(8'h3C);
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy_rise: got %b expected 1", o_busy); end
    bc = 1;
    count_fill(bc, dc, gap);
    n_cmp++; if (bc != 16) begin n_fail++; $display("FAIL fill_busy_len: got %0d expected 16", bc); end
    n_cmp++; if (dc != 1) begin n_fail++; $display("FAIL fill_done_cnt: got %0d expected 1", dc); end
    n_cmp++; if (gap != 1) begin n_fail++; $display("FAIL fill_done_gap: got %0d expected 1", gap); end
    for (int a = 0; a < DP; a++) begin
      do_read(AW'(a), d, v);
      n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL fill_read[%0d]: got %h expected 3c", a, d); end
    end
  endtask

  task automatic test_read_during_fill();
    int bc, dc, gap;
    logic [DW-1:0] d;
    logic v;
    start_fill(8'h00);
    tick();
    tick();
    do_read(4'd0, d, v);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_fill_written: got %h expected 00", d); end
    do_read(4'd15, d, v);
    n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL mid_fill_old: got %h expected 3c", d); end
    bc = 0;
    count_fill(bc, dc, gap);
    n_cmp++; if (dc != 1) begin n_fail++; $display("FAIL mid_fill_done: got %0d expected 1", dc); end
  endtask

  task automatic test_fill_ignored();
    int bc, dc, gap;
    logic [DW-1:0] d;
    logic v;
    start_fill(8'h3C);
    bc = int'(o_busy);
    tick(); bc += int'(o_busy);
    tick(); bc += int'(o_busy);
    i_waddr = 4'd15; i_wdata = 8'hFF; i_write = 1'b1;
    i_fill_data = 8'h99; i_fill_start = 1'b1;
    tick(); bc += int'(o_busy);
    i_write = 1'b0; i_fill_start = 1'b0;
    count_fill(bc, dc, gap);
    n_cmp++; if (bc != 16) begin n_fail++; $display("FAIL ignore_busy_len: got %0d expected 16", bc); end
    n_cmp++; if (dc != 1) begin n_fail++; $display("FAIL ignore_done_cnt: got %0d expected 1", dc); end
    do_read(4'd15, d, v);
    n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL ignore_addr15: got %h expected 3c", d); end
    do_read(4'd14, d, v);
    n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL ignore_addr14: got %h expected 3c", d); end
  endtask

  task automatic test_back_to_back();
    int bc, dc, gap;
    start_fill(8'h3C);
    for (int i = 0; i < 40; i++) begin
      if (o_done) break;
      tick();
    end
    n_cmp++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_seen: got %b expected 1", o_done); end
    start_fill(8'h3C);
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got %b expected 0", o_busy); end
    start_fill(8'h3C);
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_in_idle: got %b expected 1", o_busy); end
    bc = 1;
    count_fill(bc, dc, gap);
    n_cmp++; if (dc != 1) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d expected 1", dc); end
  endtask

  task automatic test_reset_abort();
    int bc, dc, gap;
    logic [DW-1:0] d;
    logic v;
    logic [DW-1:0] exp;
    start_fill(8'h00);
    bc = 1;
    count_fill(bc, dc, gap);
    start_fill(8'h77);
    repeat (5) tick();
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", o_done); end
    n_cmp++; if (o_rdata !== 8'h00) begin n_fail++; $display("FAIL abort_rdata: got %h expected 00", o_rdata); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bc = 0;
    count_fill(bc, dc, gap);
    n_cmp++; if (dc != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", dc); end
    n_cmp++; if (bc != 0) begin n_fail++; $display("FAIL abort_no_busy: got %0d expected 0", bc); end
    for (int a = 0; a < DP; a++) begin
      exp = (a < 5) ? 8'h77 : 8'h00;
      do_read(AW'(a), d, v);
      n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL abort_read[%0d]: got %h expected %h", a, d, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_first();
    test_fill();
    test_read_during_fill();
    test_fill_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_dp_fill.md
SRAM_DP_FILL -- requirements
Module: sram_dp_fill

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the address bus width for both ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the word width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning the number of words, with DEPTH <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter MEMFILE, default "", meaning the hex init file; when empty, no file is loaded.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_waddr, input, ADDR_WIDTH bits: the write address.
REQ-008 The block SHALL have port i_write, input, 1 bit: the write strobe.
REQ-009 The block SHALL have port i_wdata, input, DATA_WIDTH bits: the write data.
REQ-010 The block SHALL have port i_raddr, input, ADDR_WIDTH bits: the read address.
REQ-011 The block SHALL have port i_read, input, 1 bit: the read strobe.
REQ-012 The block SHALL have port o_rdata, output, DATA_WIDTH bits: the registered read data.
REQ-013 The block SHALL have port o_rvalid, output, 1 bit: the read data valid flag.
REQ-014 The block SHALL have port i_fill_start, input, 1 bit: the fill request pulse.
REQ-015 The block SHALL have port i_fill_data, input, DATA_WIDTH bits: the fill value, sampled on an accepted request.
REQ-016 The block SHALL have port o_busy, output, 1 bit: high while the fill engine owns the write port.
REQ-017 The block SHALL have port o_done, output, 1 bit: a one-cycle pulse on fill completion.

Function
REQ-018 Write and read ports SHALL operate independently in the same cycle.
REQ-019 A read SHALL have latency 1: i_read at edge N gives o_rdata = mem[i_raddr] and o_rvalid = 1 after edge N; with i_read low, o_rvalid = 0 and o_rdata holds its last value.
REQ-020 A same-address read and write in one cycle SHALL return the old data (read-first).
REQ-021 A write with i_waddr >= DEPTH SHALL be ignored, and a read with i_raddr >= DEPTH SHALL return 0 with o_rvalid = 1.
REQ-022 When idle, i_fill_start SHALL be accepted: it captures i_fill_data and sets o_busy = 1 from the next cycle.
REQ-023 The fill engine SHALL have states IDLE, FILL, DONE: IDLE goes to FILL on an accepted start; FILL goes to DONE after the write at address DEPTH-1; DONE goes to IDLE after 1 cycle.
REQ-024 In FILL, the block SHALL write the fill value to addresses 0 through DEPTH-1, one per cycle, with the counter incrementing from 0 and never wrapping.
REQ-025 o_busy SHALL be high for exactly DEPTH cycles, and o_done SHALL be high for exactly 1 cycle, in the cycle after o_busy falls (DONE state).
REQ-026 While o_busy = 1, user writes SHALL be dropped silently, and i_fill_start SHALL be ignored.
REQ-027 Reads SHALL remain serviced during a fill and return the current contents: fill value for addresses already written, old data otherwise.
REQ-028 If i_fill_start and i_write occur in the same idle cycle, the user write SHALL be performed, then be overwritten by the fill.
REQ-029 i_fill_start in the DONE cycle SHALL be ignored, so a new fill is accepted from IDLE only.

Reset
REQ-030 Asserting i_rst_n low SHALL immediately force o_rdata = 0, o_rvalid = 0, o_busy = 0, o_done = 0, fill state = IDLE and fill counter = 0.
REQ-031 Reset SHALL NOT alter memory contents.
REQ-032 A reset during FILL SHALL abort the fill, leave the memory partially filled, and produce no o_done pulse.
REQ-033 Release of i_rst_n SHALL be sampled on the rising edge of i_clk, and the first operation SHALL be accepted on the first edge after release.

Configuration
REQ-034 With macro SRAM_OUTREG_EN defined, the block SHALL add one output pipeline register to o_rdata and o_rvalid, giving read latency 2; that register SHALL reset to 0.
REQ-035 With SRAM_OUTREG_EN undefined, read latency SHALL be 1 as in REQ-019.
REQ-036 SRAM_OUTREG_EN SHALL NOT change fill timing, o_busy or o_done.

Verification (DEPTH=16, ADDR_WIDTH=4, DATA_WIDTH=8, macro undefined unless stated)
REQ-037 Bench case: write 0xA5 to addr 3, read addr 3 next cycle -> o_rdata = 0xA5, o_rvalid = 1 one cycle after i_read.
REQ-038 Bench case: write 0x11 to addr 5 and read addr 5 in the same cycle, where the old value is 0x22 -> o_rdata = 0x22; a re-read returns 0x11.
REQ-039 Bench case: i_fill_start with i_fill_data = 0x3C -> o_busy high for 16 cycles, o_done one pulse, reads of addrs 0..15 all return 0x3C.
REQ-040 Bench case: during a fill, write 0xFF to addr 15 and pulse i_fill_start again -> both ignored; addr 15 reads 0x3C; o_busy length stays 16.
REQ-041 Bench case: fill 0x77 over 0x00 contents, assert i_rst_n low after 5 busy cycles -> o_busy = 0 immediately, no o_done; addrs 0..4 read 0x77, addrs 5..15 read 0x00.
REQ-042 Bench case: SRAM_OUTREG_EN defined, write 0x5A to addr 0, read addr 0 -> o_rvalid and o_rdata = 0x5A two cycles after i_read.
